// File: rtl/latch_feeder_pkg.sv
// Shared types and default timing for the latch feeder.
// Holds the sequencer state encoding and a small helper used for sizing.
package latch_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } fsm_state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_EN_CYC    = 2;
    localparam int DEF_HOLD_CYC  = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; full/empty derive from the level count.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage array: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/latch_feeder_8bit.sv
// Drives a level-sensitive latch from a buffered byte stream using a
// setup / enable-pulse / hold sequence with all latch-facing pins from flops.
module latch_feeder_8bit
    import latch_feeder_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int EN_CYC    = DEF_EN_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] lat_data,
    output logic              lat_en,
    output logic              busy,
    output logic [LVL_W-1:0]  level
);

    localparam int PH_W = $clog2(max3(SETUP_CYC, EN_CYC, HOLD_CYC)) + 1;

    fsm_state_t        state_r;
    fsm_state_t        state_nxt_s;
    logic [PH_W-1:0]   phase_r;
    logic [PH_W-1:0]   phase_nxt_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [DATA_W-1:0] head_s;
    logic [DATA_W-1:0] lat_data_r;
    logic              lat_en_r;
    logic              busy_r;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .pop     (pop_s),
        .wr_data (in_data),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (level)
    );

    assign in_ready = !full_s;
    assign lat_data = lat_data_r;
    assign lat_en   = lat_en_r;
    assign busy     = busy_r;

    // Next-state and phase reload; the phase counter counts down to zero in each state.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = SETUP;
                    phase_nxt_s = PH_W'(SETUP_CYC - 1);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                if (phase_r == {PH_W{1'b0}}) begin
                    state_nxt_s = PULSE;
                    phase_nxt_s = PH_W'(EN_CYC - 1);
                end else begin
                    phase_nxt_s = phase_r - PH_W'(1);
                end
            end
            PULSE: begin
                if (phase_r == {PH_W{1'b0}}) begin
                    state_nxt_s = HOLD;
                    phase_nxt_s = PH_W'(HOLD_CYC - 1);
                end else begin
                    phase_nxt_s = phase_r - PH_W'(1);
                end
            end
            HOLD: begin
                if (phase_r == {PH_W{1'b0}}) begin
                    state_nxt_s = IDLE;
                    phase_nxt_s = {PH_W{1'b0}};
                end else begin
                    phase_nxt_s = phase_r - PH_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                phase_nxt_s = {PH_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and output flops; lat_en is a pure flop so the latch never sees a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            phase_r    <= {PH_W{1'b0}};
            lat_data_r <= {DATA_W{1'b0}};
            lat_en_r   <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            phase_r  <= phase_nxt_s;
            lat_en_r <= (state_nxt_s == PULSE);
            busy_r   <= (state_nxt_s != IDLE);
            if (pop_s) begin
                lat_data_r <= head_s;
            end else begin
                lat_data_r <= lat_data_r;
            end
        end
    end

endmodule

// File: tb/tb_latch_feeder_8bit.sv
// Bench for latch_feeder_8bit: a default-timing instance and a (3,1,2) instance,
// checked every cycle against a transaction-schedule model plus directed checks.
module tb_latch_feeder_8bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       v [2];
    logic [7:0] d [2];

    logic       rdy0, le0, lb0, rdy1, le1, lb1;
    logic [7:0] ld0, ld1;
    logic [2:0] ll0, ll1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // schedule model state, per instance
    int         acc_n [2];
    int         pop_n [2];
    int         last_pop [2];
    int         acc_e [2][64];
    logic [7:0] mem_m [2][64];
    logic [7:0] exp_d [2];
    logic       acc_last [2];

    // external latch model and pulse capture log
    logic [7:0] latch_q [2];
    logic       prev_en [2];
    logic [7:0] cap [2][32];
    int         cap_n [2];

    latch_feeder_8bit u_dut0 (
        .clk(clk), .rst(rst), .in_data(d[0]), .in_valid(v[0]), .in_ready(rdy0),
        .lat_data(ld0), .lat_en(le0), .busy(lb0), .level(ll0)
    );

    latch_feeder_8bit #(.SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_data(d[1]), .in_valid(v[1]), .in_ready(rdy1),
        .lat_data(ld1), .lat_en(le1), .busy(lb1), .level(ll1)
    );

    function automatic int s_of(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int e_of(input int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int h_of(input int i); return (i == 0) ? 1 : 2; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear(input int i);
        acc_n[i]    = 0;
        pop_n[i]    = 0;
        last_pop[i] = -1000;
        exp_d[i]    = 8'h00;
        acc_last[i] = 1'b0;
        prev_en[i]  = 1'b0;
    endtask

    // One rising edge of the reference: pops follow the transaction period, pushes obey the level.
    task automatic model_edge(input int i);
        int  lvl, per;
        bit  do_pop;
        if (rst) begin
            model_clear(i);
        end else begin
            per    = 1 + s_of(i) + e_of(i) + h_of(i);
            lvl    = acc_n[i] - pop_n[i];
            do_pop = (pop_n[i] < acc_n[i]) && (acc_e[i][pop_n[i] % 64] < cyc)
                     && (cyc >= last_pop[i] + per);
            acc_last[i] = v[i] && (lvl != 4);
            if (do_pop) begin
                exp_d[i]    = mem_m[i][pop_n[i] % 64];
                last_pop[i] = cyc;
                pop_n[i]++;
            end
            if (acc_last[i]) begin
                mem_m[i][acc_n[i] % 64] = d[i];
                acc_e[i][acc_n[i] % 64] = cyc;
                acc_n[i]++;
            end
        end
    endtask

    task automatic compare(input int i);
        logic [7:0] ld;
        logic       le, lb, lr;
        logic [2:0] ll;
        int         lp, s, e, h, lvl;
        if (i == 0) begin
            ld = ld0; le = le0; lb = lb0; lr = rdy0; ll = ll0;
        end else begin
            ld = ld1; le = le1; lb = lb1; lr = rdy1; ll = ll1;
        end
        lp  = last_pop[i];
        s   = s_of(i);
        e   = e_of(i);
        h   = h_of(i);
        lvl = acc_n[i] - pop_n[i];
        check($sformatf("d%0d_lat_en", i), le, (cyc >= lp + s) && (cyc < lp + s + e));
        check($sformatf("d%0d_lat_data", i), ld, exp_d[i]);
        check($sformatf("d%0d_busy", i), lb, (cyc >= lp) && (cyc < lp + s + e + h));
        check($sformatf("d%0d_level", i), ll, lvl);
        check($sformatf("d%0d_in_ready", i), lr, lvl != 4);
        if (le) latch_q[i] = ld;
        if (le && !prev_en[i] && cap_n[i] < 32) begin
            cap[i][cap_n[i]] = ld;
            cap_n[i]++;
        end
        prev_en[i] = le;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        compare(0);
        compare(1);
    endtask

    task automatic push(input int i, input logic [7:0] b);
        bit got = 1'b0;
        v[i] = 1'b1;
        d[i] = b;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            got = acc_last[i];
        end
        v[i] = 1'b0;
        check("push_accepted", got, 1'b1);
    endtask

    task automatic stream(input int i, input logic [7:0] base, input int n, output bit saw_full);
        int sent = 0;
        saw_full = 1'b0;
        v[i] = 1'b1;
        d[i] = base;
        for (int k = 0; k < 100 && sent < n; k++) begin
            step();
            if (ll0 == 3'd4 && !rdy0) saw_full = 1'b1;
            if (acc_last[i]) begin
                sent++;
                d[i] = base + 8'(sent);
            end
        end
        v[i] = 1'b0;
        check("stream_all_accepted", sent, n);
    endtask

    initial begin
        bit   full_seen;
        logic got_en;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; d[i] = 8'h00; latch_q[i] = 8'h00; cap_n[i] = 0;
            model_clear(i);
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        check("reset_lat_data", ld0, 8'h00);
        check("reset_lat_en", le0, 1'b0);
        check("reset_in_ready", rdy0, 1'b1);
        check("reset_level", ll0, 3'd0);

        // single byte, default timing
        push(0, 8'hA5);
        step(); check("a5_data_setup", ld0, 8'hA5); check("a5_en_setup", le0, 1'b0);
        step(); check("a5_en_hi1", le0, 1'b1);
        step(); check("a5_en_hi2", le0, 1'b1);
        step(); check("a5_en_hold", le0, 1'b0); check("a5_data_hold", ld0, 8'hA5);
        step(); check("a5_idle", lb0, 1'b0);
        check("a5_latch_out", latch_q[0], 8'hA5);

        // continuous stream 01..06 overflows the FIFO and backpressures
        cap_n[0] = 0;
        stream(0, 8'h01, 6, full_seen);
        check("stream_full_seen", full_seen, 1'b1);
        repeat (30) step();
        check("stream_pulse_count", cap_n[0], 6);
        for (int j = 0; j < 6; j++) check($sformatf("stream_byte%0d", j), cap[0][j], 8'(j + 1));

        // asynchronous reset in the middle of a pulse with 3 bytes queued
        stream(0, 8'hB1, 4, full_seen);
        got_en = le0;
        for (int k = 0; k < 10 && !got_en; k++) begin
            step();
            got_en = le0;
        end
        check("rst_in_pulse", le0, 1'b1);
        check("rst_queued", ll0, 3'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_async_en", le0, 1'b0);
        check("rst_async_data", ld0, 8'h00);
        check("rst_async_level", ll0, 3'd0);
        check("rst_async_ready", rdy0, 1'b1);
        #1 rst = 1'b0;
        model_clear(0);
        model_clear(1);
        cap_n[0] = 0;
        repeat (15) step();
        check("rst_no_pulses", cap_n[0], 0);

        // push coinciding with pop of the single stored entry
        stream(0, 8'hC1, 2, full_seen);
        check("collide_level", ll0, 3'd1);
        repeat (15) step();
        check("collide_count", cap_n[0], 2);
        check("collide_first", cap[0][0], 8'hC1);
        check("collide_second", cap[0][1], 8'hC2);

        // alternate timing instance: setup 3, enable 1, hold 2
        push(1, 8'h3C);
        step(); check("t2_data", ld1, 8'h3C); check("t2_en_s1", le1, 1'b0);
        step(); check("t2_en_s2", le1, 1'b0);
        step(); check("t2_en_s3", le1, 1'b0);
        step(); check("t2_en_hi", le1, 1'b1);
        step(); check("t2_en_h1", le1, 1'b0); check("t2_data_h1", ld1, 8'h3C);
        step(); check("t2_en_h2", le1, 1'b0); check("t2_data_h2", ld1, 8'h3C);
        step(); check("t2_idle", lb1, 1'b0);
        check("t2_latch_out", latch_q[1], 8'h3C);

        // random traffic on both instances; source holds data until accepted
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || acc_last[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    d[i] = 8'($urandom);
                end
            end
            step();
        end
        v[0] = 1'b0;
        v[1] = 1'b0;
        repeat (50) step();
        check("rand_drained0", ll0, 3'd0);
        check("rand_drained1", ll1, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
